// File: rtl/demod_pipe_scheduler.sv
// demod_pipe_scheduler
// Round-robin front end for one shared, free-running demodulation pipeline.
// Grants at most one requesting word per cycle and registers it onto the
// pipeline input. A tag (valid + requester id) travels beside the word so the
// pipeline result comes back labelled with the requester that issued it.
//
// Handshake: a requester holds req[i] high with its word on req_data until a
// cycle where grant[i] is also high; that cycle consumes the word. The next
// cycle the requester either presents its next word with req[i] still high or
// drops req[i]. grant is combinational and never depends on a downstream
// ready, because the pipeline never stalls.
module demod_pipe_scheduler #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int LATENCY = 3,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_data,
    input  logic [N_REQ-1:0]   enable_mask,
    input  logic               flush,
    output logic [N_REQ-1:0]   grant,
    output logic [W-1:0]       pipe_in,
    output logic               out_valid,
    output logic [IDW-1:0]     out_id,
    output logic               busy,
    output logic [15:0]        issue_count
);

    // Stage 0 sits beside pipe_in; LATENCY more stages follow the pipeline,
    // so the last stage lines up with the pipeline output word.
    localparam int STAGES = LATENCY + 1;

    logic [IDW-1:0]            last;
    logic [N_REQ-1:0]          eligible;
    logic                      win_found;
    logic [IDW-1:0]            win_id;
    logic [IDW-1:0]            idx;
    logic [N_REQ-1:0][W-1:0]   data_arr;
    logic [STAGES-1:0]         tag_valid;
    logic [IDW-1:0]            tag_id [STAGES];

    assign data_arr = req_data;

    // Flush and reset both suppress every request for the cycle.
    assign eligible = (reset && !flush) ? (req & enable_mask) : '0;

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        grant     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last + IDW'(k);
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
        if (win_found) begin
            grant[win_id] = 1'b1;
        end
    end

    // Arbitration pointer, pipeline input word and grant counter move only on a grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last        <= IDW'(N_REQ - 1);
            pipe_in     <= '0;
            issue_count <= '0;
        end else if (win_found) begin
            last        <= win_id;
            pipe_in     <= data_arr[win_id];
            issue_count <= issue_count + 16'd1;
        end
    end

    // Tag shift register; flush kills every in-flight valid, ids just ride along.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_valid[0] <= win_found;
            tag_id[0]    <= win_id;
            for (int s = 1; s < STAGES; s++) begin
                tag_valid[s] <= tag_valid[s-1] && !flush;
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    assign out_valid = tag_valid[STAGES-1];
    assign out_id    = tag_id[STAGES-1];
    assign busy      = |tag_valid;

endmodule
